// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the iterative IEEE-754 divider and its rounding stage.
package fp_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } flags_t;

    localparam int FLAG_INVALID     = 3;
    localparam int FLAG_DIV_BY_ZERO = 2;
    localparam int FLAG_OVERFLOW    = 1;
    localparam int FLAG_UNDERFLOW   = 0;

    function automatic int exp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Wide enough for any practical format; callers keep the low 1+EW+MW bits.
    function automatic logic [127:0] qnan_bits(input int ew, input int mw);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < ew; i++) r[mw + i] = 1'b1;
        r[mw - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for fp_div_iter.
interface fp_div_iter_if #(
    parameter int EW = 8,
    parameter int MW = 23
);
    localparam int DW = 1 + EW + MW;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] C;
    logic [3:0]    flags;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, C, flags
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, C, flags
    );
endinterface

// File: rtl/fp_div_round.sv
// Normalise a raw quotient, round to nearest even and pack it, flushing to zero or inf on range exit.
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic                 sign,
    input  logic signed [EW+1:0] expo,
    input  logic [MW+2:0]        quot,
    input  logic                 rem_nz,
    output logic [EW+MW:0]       res,
    output logic                 overflow,
    output logic                 underflow
);
    localparam logic signed [EW+1:0] ONE     = (EW+2)'(1);
    localparam logic signed [EW+1:0] ZERO    = (EW+2)'(0);
    localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'((1 << EW) - 1);

    logic                 norm;
    logic                 lsb;
    logic                 guard;
    logic                 sticky;
    logic                 rnd_up;
    logic                 carry;
    logic [MW+1:0]        qn;
    logic [MW:0]          frac_sum;
    logic signed [EW+1:0] exp_n;
    logic signed [EW+1:0] exp_r;

    always_comb begin
        norm     = quot[MW+2];
        // qn drops the hidden bit: fraction in [MW+1:2], guard in [1], one extra sticky bit in [0]
        qn       = norm ? quot[MW+1:0] : {quot[MW:0], 1'b0};
        exp_n    = norm ? expo : expo - ONE;
        lsb      = qn[2];
        guard    = qn[1];
        sticky   = qn[0] | rem_nz;
        rnd_up   = guard & (sticky | lsb);
        frac_sum = {1'b0, qn[MW+1:2]} + {{MW{1'b0}}, rnd_up};
        carry    = frac_sum[MW];
        exp_r    = carry ? exp_n + ONE : exp_n;

        overflow  = (exp_r >= EXP_MAX);
        underflow = !overflow && (exp_r <= ZERO);

        if (overflow)
            res = {sign, {EW{1'b1}}, {MW{1'b0}}};
        else if (underflow)
            res = {sign, {(EW+MW){1'b0}}};
        else
            res = {sign, exp_r[EW-1:0], frac_sum[MW-1:0]};
    end
endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: restoring radix-2, one quotient bit per cycle, RNE, DAZ inputs, FTZ outputs.
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input logic         clk,
    input logic         rst,
    fp_div_iter_if.slave bus
);
    localparam int                   DW        = 1 + EW + MW;
    localparam int                   CW        = $clog2(MW + 3);
    localparam logic [CW-1:0]        LAST      = CW'(MW + 2);
    localparam logic signed [EW+1:0] BIAS      = (EW+2)'(exp_bias(EW));
    localparam logic [127:0]         QNAN_FULL = qnan_bits(EW, MW);
    localparam logic [DW-1:0]        QNAN      = QNAN_FULL[DW-1:0];

    state_t               state;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [DW-1:0]        a_r;
    logic [DW-1:0]        b_r;
    logic [DW-1:0]        c_r;
    flags_t               flags_r;
    logic                 sign_r;
    logic signed [EW+1:0] exp_r;
    logic [MW+1:0]        rem;
    logic [MW:0]          dvs;
    logic [MW+2:0]        quo;
    logic [CW-1:0]        cnt;

    op_class_t     cls_a;
    op_class_t     cls_b;
    logic          sign_ab;
    logic          spec_hit;
    logic [DW-1:0] spec_c;
    flags_t        spec_flags;
    logic [MW+2:0] diff;
    logic [MW+1:0] rem_sel;
    logic [DW-1:0] rnd_res;
    logic          rnd_ovf;
    logic          rnd_unf;

    function automatic op_class_t classify(input logic [EW-1:0] e, input logic [MW-1:0] f);
        if (e == '0) return CLS_ZERO;
        if (e != '1) return CLS_NORM;
        return (f == '0) ? CLS_INF : CLS_NAN;
    endfunction

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.C         = c_r;
    assign bus.flags     = flags_r;

    always_comb begin
        cls_a      = classify(a_r[DW-2:MW], a_r[MW-1:0]);
        cls_b      = classify(b_r[DW-2:MW], b_r[MW-1:0]);
        sign_ab    = a_r[DW-1] ^ b_r[DW-1];
        spec_hit   = 1'b1;
        spec_c     = QNAN;
        spec_flags = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            spec_c = QNAN;
        end else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            spec_flags.invalid = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_c = {sign_ab, {EW{1'b1}}, {MW{1'b0}}};
        end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
            spec_c = {sign_ab, {(EW+MW){1'b0}}};
        end else if (cls_b == CLS_ZERO) begin
            spec_c                 = {sign_ab, {EW{1'b1}}, {MW{1'b0}}};
            spec_flags.div_by_zero = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Restoring step: a clear sign bit on the trial difference means the divisor fits.
    always_comb begin
        diff    = {1'b0, rem} - {2'b00, dvs};
        rem_sel = diff[MW+2] ? rem : diff[MW+1:0];
    end

    fp_div_round #(.EW(EW), .MW(MW)) u_round (
        .sign      (sign_r),
        .expo      (exp_r),
        .quot      (quo),
        .rem_nz    (|rem),
        .res       (rnd_res),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            c_r         <= '0;
            flags_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.A;
                        b_r        <= bus.B;
                        in_ready_r <= 1'b0;
                        state      <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_r <= sign_ab;
                    if (spec_hit) begin
                        c_r         <= spec_c;
                        flags_r     <= spec_flags;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        rem   <= {1'b0, 1'b1, a_r[MW-1:0]};
                        dvs   <= {1'b1, b_r[MW-1:0]};
                        quo   <= '0;
                        cnt   <= '0;
                        exp_r <= $signed({2'b00, a_r[DW-2:MW]}) - $signed({2'b00, b_r[DW-2:MW]}) + BIAS;
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem <= rem_sel << 1;
                    quo <= {quo[MW+1:0], ~diff[MW+2]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_ROUND;
                end
                S_ROUND: begin
                    c_r         <= rnd_res;
                    flags_r     <= '{invalid: 1'b0, div_by_zero: 1'b0, overflow: rnd_ovf, underflow: rnd_unf};
                    out_valid_r <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed vector table, back-pressure and reset sequences, random ops vs. an exact-arithmetic model.
module tb_fp_div_iter;
    import fp_div_pkg::*;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fp_div_iter_if #(.EW(EW), .MW(MW)) bus ();

    fp_div_iter #(.EW(EW), .MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exact rational model: quotient of significands rounded by comparing twice the remainder with the divisor.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output logic [3:0] fl, output int lat);
        int     ea, eb, e;
        bit     az, bz, ai, bi, an, bn, s;
        longint num, den, qq, rr;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        s  = a[31] ^ b[31];
        fl  = 4'b0000;
        lat = 2;
        if (an || bn) begin
            c = QNAN;
        end else if ((az && bz) || (ai && bi)) begin
            c = QNAN;
            fl[FLAG_INVALID] = 1'b1;
        end else if (ai) begin
            c = {s, 8'hFF, 23'h0};
        end else if (bi || az) begin
            c = {s, 31'h0};
        end else if (bz) begin
            c = {s, 8'hFF, 23'h0};
            fl[FLAG_DIV_BY_ZERO] = 1'b1;
        end else begin
            lat = MW + 6;
            num = longint'({1'b1, a[22:0]});
            den = longint'({1'b1, b[22:0]});
            e   = ea - eb + 127;
            if (num < den) begin
                num = num * 2;
                e   = e - 1;
            end
            qq = (num << 23) / den;
            rr = (num << 23) % den;
            if ((2 * rr > den) || ((2 * rr == den) && qq[0])) qq = qq + 1;
            if (qq == (64'd1 << 24)) begin
                qq = qq >> 1;
                e  = e + 1;
            end
            if (e >= 255) begin
                c = {s, 8'hFF, 23'h0};
                fl[FLAG_OVERFLOW] = 1'b1;
            end else if (e <= 0) begin
                c = {s, 31'h0};
                fl[FLAG_UNDERFLOW] = 1'b1;
            end else begin
                c = {s, e[7:0], qq[22:0]};
            end
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int          kind;
        kind = $urandom_range(0, 15);
        v    = $urandom;
        case (kind)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2: begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
            3, 4, 5: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Inputs are driven and outputs sampled on the falling edge; lat counts rising edges from accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          output logic [31:0] c, output logic [3:0] fl, output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 100 cycles");
        end
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.B        = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL out_valid_wait: got 0 expected 1 within 100 cycles");
        end
        c  = bus.C;
        fl = bus.flags;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    vec_t        vecs[11];
    logic [31:0] c, ec, c0;
    logic [3:0]  fl, ef, f0;
    int          lat, elat, n;
    bit          seen;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{32'h40C00000, 32'hBF000000, 32'hC1400000, 4'b0000, 29};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29};
        vecs[2]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 29};
        vecs[3]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2};
        vecs[8]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 2};
        vecs[9]  = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 2};
        vecs[10] = '{32'h40000000, 32'h40000000, 32'h3F800000, 4'b0000, 29};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_C", bus.C, 0);
        check("reset_flags", bus.flags, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 0, c, fl, lat);
            check($sformatf("vec%0d_C", i), c, vecs[i].c);
            check($sformatf("vec%0d_flags", i), fl, vecs[i].fl);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Back-pressure: result must hold and new requests must be ignored.
        bus.A = 32'h40C00000;
        bus.B = 32'hBF000000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        c0 = bus.C;
        f0 = bus.flags;
        check("bp_C_first", c0, 32'hC1400000);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.A = 32'h3F800000;
            bus.B = 32'h40400000;
            @(negedge clk);
            check("bp_C_hold", bus.C, c0);
            check("bp_flags_hold", bus.flags, f0);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check("bp_idle_out_valid", bus.out_valid, 0);
        check("bp_idle_in_ready", bus.in_ready, 1);

        // Reset during DIVIDE discards the operation.
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_C", bus.C, 0);
        check("midrst_flags", bus.flags, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_result", seen, 0);
        run_op(32'h3F800000, 32'h40400000, 0, c, fl, lat);
        check("midrst_after_C", c, 32'h3EAAAAAB);
        check("midrst_after_flags", fl, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            a = rand_operand();
            b = rand_operand();
            model(a, b, ec, ef, elat);
            run_op(a, b, $urandom_range(0, 2), c, fl, lat);
            check($sformatf("rnd%0d_C(%h/%h)", i, a, b), c, ec);
            check($sformatf("rnd%0d_flags(%h/%h)", i, a, b), fl, ef);
            check($sformatf("rnd%0d_latency", i), lat, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
